// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle datapath: sequences strobes and ALU ops per instruction.
// Latency: R/I/SW 4 cycles, LW 5, BEQ/BNE/J/illegal 3; each mem_ready=0 cycle in a memory state adds one.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold (strobes steady) until mem_ready.
module multicycle_control_fsm #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [2:0]         opalu,
    output logic [5:0]         alu_funct,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [STATE_W-1:0] state_dbg
);

    typedef enum logic [STATE_W-1:0] {
        FETCH     = STATE_W'(0),
        DECODE    = STATE_W'(1),
        MEM_ADDR  = STATE_W'(2),
        MEM_READ  = STATE_W'(3),
        MEM_WB    = STATE_W'(4),
        MEM_WRITE = STATE_W'(5),
        R_EXEC    = STATE_W'(6),
        R_WB      = STATE_W'(7),
        BRANCH    = STATE_W'(8),
        JUMP      = STATE_W'(9),
        I_EXEC    = STATE_W'(10),
        I_WB      = STATE_W'(11),
        ILLEGAL   = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    state_t state_q;
    state_t state_d;
    logic   mrdy;

    assign mrdy      = USE_MEM_READY ? mem_ready : 1'b1;
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        opalu      = 3'b000;
        alu_funct  = funct;
        illegal_op = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mrdy;
                pc_en     = mrdy;
                state_d   = mrdy ? DECODE : FETCH;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:                         state_d = R_EXEC;
                    OP_LW, OP_SW:                     state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE:                   state_d = BRANCH;
                    OP_J:                             state_d = JUMP;
                    OP_ADDI, OP_ANDI, OP_XORI, OP_SLTI: state_d = I_EXEC;
                    default:                          state_d = ILLEGAL;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mrdy ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mrdy;
                state_d    = mrdy ? FETCH : MEM_WRITE;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                opalu     = 3'b010;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                opalu      = 3'b001;
                pc_source  = 2'b01;
                pc_en      = (opcode == OP_BNE) ? !zero : zero;
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_source  = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Logical/compare immediates let the ALU decoder see the opcode.
                if (opcode == OP_ANDI || opcode == OP_XORI || opcode == OP_SLTI) begin
                    opalu     = 3'b011;
                    alu_funct = opcode;
                end
                state_d = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ILLEGAL: begin
                illegal_op = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // While reset is held, present the idle FETCH-like values with every strobe off.
        if (!reset_n) begin
            pc_en      = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            pc_source  = 2'b00;
            opalu      = 3'b000;
            alu_funct  = funct;
            illegal_op = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: vector table, directed corner sequences, and a
// randomized instruction stream checked against an instruction-level expansion model.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] opalu;
    logic [5:0] alu_funct;
    logic       illegal_op, instr_done;
    logic [3:0] state_dbg;

    int n_chk  = 0;
    int n_fail = 0;

    multicycle_control_fsm #(.USE_MEM_READY(1'b1), .STATE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .opalu(opalu),
        .alu_funct(alu_funct), .illegal_op(illegal_op), .instr_done(instr_done),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] opalu;
        logic [5:0] alu_funct;
        logic       illegal_op, instr_done;
        logic [3:0] state;
    } out_t;

    out_t act;
    assign act = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, pc_source, opalu, alu_funct, illegal_op, instr_done,
                  state_dbg};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called right after a falling edge; leaves the FSM in FETCH at the next falling edge.
    task automatic do_reset(input logic mr);
        reset_n   = 1'b0;
        mem_ready = mr;
        #1;
        chk("rst_strobes", {25'd0, pc_en, mem_read, mem_write, ir_write, reg_write, illegal_op, instr_done}, 32'd0);
        chk("rst_muxes", {14'd0, alu_src_a, alu_src_b, pc_source, opalu, i_or_d, reg_dst, mem_to_reg, alu_funct},
            {14'd0, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, funct});
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- instruction-level reference model ----------------
    bit   mr_q[$];
    out_t exp_q[$];

    function automatic out_t base(input logic [3:0] st, input logic [5:0] fn);
        out_t o = '0;
        o.alu_funct = fn;
        o.state     = st;
        return o;
    endfunction

    task automatic push(input bit mr, input out_t o);
        mr_q.push_back(mr);
        exp_q.push_back(o);
    endtask

    // Expand one instruction into its expected per-cycle trace. sf/sm are the
    // stall cycles inserted in the instruction fetch and in the data access.
    task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z, input int sf, input int sm);
        out_t o;
        for (int i = 0; i < sf; i++) begin
            o = base(0, fn); o.mem_read = 1; o.alu_src_b = 2'b01; push(0, o);
        end
        o = base(0, fn); o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = 1; o.pc_en = 1; push(1, o);
        o = base(1, fn); o.alu_src_b = 2'b11; push($urandom_range(0, 1), o);
        if (op == 6'b000000) begin
            o = base(6, fn); o.alu_src_a = 1; o.opalu = 3'b010; push($urandom_range(0, 1), o);
            o = base(7, fn); o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; push($urandom_range(0, 1), o);
        end else if (op == 6'b100011 || op == 6'b101011) begin
            o = base(2, fn); o.alu_src_a = 1; o.alu_src_b = 2'b10; push($urandom_range(0, 1), o);
            if (op == 6'b100011) begin
                for (int i = 0; i <= sm; i++) begin
                    o = base(3, fn); o.mem_read = 1; o.i_or_d = 1; push(i == sm, o);
                end
                o = base(4, fn); o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; push($urandom_range(0, 1), o);
            end else begin
                for (int i = 0; i <= sm; i++) begin
                    o = base(5, fn); o.mem_write = 1; o.i_or_d = 1; o.instr_done = (i == sm); push(i == sm, o);
                end
            end
        end else if (op == 6'b000100 || op == 6'b000101) begin
            o = base(8, fn); o.alu_src_a = 1; o.opalu = 3'b001; o.pc_source = 2'b01;
            o.pc_en = (op == 6'b000100) ? z : !z; o.instr_done = 1; push($urandom_range(0, 1), o);
        end else if (op == 6'b000010) begin
            o = base(9, fn); o.pc_source = 2'b10; o.pc_en = 1; o.instr_done = 1; push($urandom_range(0, 1), o);
        end else if (op == 6'b001000 || op == 6'b001100 || op == 6'b001110 || op == 6'b001010) begin
            o = base(10, fn); o.alu_src_a = 1; o.alu_src_b = 2'b10;
            if (op != 6'b001000) begin o.opalu = 3'b011; o.alu_funct = op; end
            push($urandom_range(0, 1), o);
            o = base(11, fn); o.reg_write = 1; o.instr_done = 1; push($urandom_range(0, 1), o);
        end else begin
            o = base(12, fn); o.illegal_op = 1; o.instr_done = 1; push($urandom_range(0, 1), o);
        end
    endtask

    // ---------------- vector table (mem_ready held 1) ----------------
    typedef struct {
        logic [5:0]  op;
        logic        z;
        int          len;
        logic [19:0] states;  // first state in the top nibble
        logic        pc_last;
        logic        rw_last;
        logic        ill_last;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [19:0] sv;
        logic [5:0]  legal[10];
        logic [5:0]  op;
        int          ill_cnt, bad_cnt;

        tbl[0]  = '{6'b000000, 1'b0, 4, 20'h01670, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{6'b100011, 1'b0, 5, 20'h01234, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{6'b101011, 1'b0, 4, 20'h01250, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{6'b000100, 1'b1, 3, 20'h01800, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{6'b000100, 1'b0, 3, 20'h01800, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{6'b000101, 1'b0, 3, 20'h01800, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{6'b000101, 1'b1, 3, 20'h01800, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{6'b000010, 1'b0, 3, 20'h01900, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{6'b001000, 1'b0, 4, 20'h01ab0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{6'b001100, 1'b0, 4, 20'h01ab0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{6'b001110, 1'b0, 4, 20'h01ab0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{6'b001010, 1'b0, 4, 20'h01ab0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{6'b111111, 1'b0, 3, 20'h01c00, 1'b0, 1'b0, 1'b1};
        legal   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                    6'b000010, 6'b001000, 6'b001100, 6'b001110, 6'b001010};

        reset_n = 1'b0; opcode = 6'b0; funct = 6'b100110; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        do_reset(1'b1);
        #1 chk("reset_state", {28'd0, state_dbg}, 32'd0);

        // Table vectors.
        for (int i = 0; i < 13; i++) begin
            opcode = tbl[i].op; zero = tbl[i].z; mem_ready = 1'b1; sv = tbl[i].states;
            for (int c = 0; c < tbl[i].len; c++) begin
                #1;
                chk($sformatf("tbl%0d_state%0d", i, c), {28'd0, state_dbg}, {28'd0, sv[19 - 4*c -: 4]});
                if (c == tbl[i].len - 1)
                    chk($sformatf("tbl%0d_last", i), {28'd0, pc_en, reg_write, illegal_op, instr_done},
                        {28'd0, tbl[i].pc_last, tbl[i].rw_last, tbl[i].ill_last, 1'b1});
                @(negedge clk);
            end
        end

        // R-type: ALU control in R_EXEC.
        do_reset(1'b1);
        opcode = 6'b000000; funct = 6'b100110; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("r_exec_alu", {23'd0, state_dbg, opalu, alu_funct}, {23'd0, 4'd6, 3'b010, 6'b100110});

        // LW with a two-cycle stall in MEM_READ.
        do_reset(1'b1);
        opcode = 6'b100011;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1 chk($sformatf("lw_stall%0d", k), {24'd0, state_dbg, mem_read, i_or_d, reg_write, instr_done},
                   {24'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0});
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1 chk("lw_ready", {28'd0, state_dbg}, 32'd3);
        @(negedge clk);
        #1 chk("lw_wb", {26'd0, state_dbg, reg_write, mem_to_reg}, {26'd0, 4'd4, 1'b1, 1'b1});
        @(negedge clk);
        #1 chk("lw_back_fetch", {28'd0, state_dbg}, 32'd0);

        // ANDI vs ADDI in I_EXEC.
        do_reset(1'b1);
        opcode = 6'b001100; funct = 6'b000000;
        repeat (2) @(negedge clk);
        #1 chk("andi_exec", {20'd0, state_dbg, opalu, alu_funct, alu_src_b}, {20'd0, 4'd10, 3'b011, 6'b001100, 2'b10});
        do_reset(1'b1);
        opcode = 6'b001000;
        repeat (2) @(negedge clk);
        #1 chk("addi_exec", {19'd0, state_dbg, opalu, alu_funct, alu_src_b}, {19'd0, 4'd10, 3'b000, 6'b000000, 2'b10});

        // Illegal opcode: exactly one illegal_op pulse, no writes.
        do_reset(1'b1);
        opcode = 6'b111111; ill_cnt = 0; bad_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            ill_cnt += int'(illegal_op);
            bad_cnt += int'(reg_write) + int'(mem_write);
            if (c == 2) chk("ill_state", {28'd0, state_dbg}, 32'd12);
            @(negedge clk);
        end
        #1 chk("ill_pulse", ill_cnt, 32'd1);
        chk("ill_no_write", bad_cnt, 32'd0);
        chk("ill_back_fetch", {28'd0, state_dbg}, 32'd0);

        // Reset while MEM_WRITE is stalled.
        do_reset(1'b1);
        opcode = 6'b101011;
        repeat (3) @(negedge clk);
        #1 chk("sw_in_write", {28'd0, state_dbg}, 32'd5);
        do_reset(1'b0);
        mem_ready = 1'b1;
        #1 chk("sw_rst_fetch", {26'd0, state_dbg, mem_read, ir_write}, {26'd0, 4'd0, 1'b1, 1'b1});
        @(negedge clk);
        #1 chk("sw_rst_decode", {28'd0, state_dbg}, 32'd1);

        // Randomized instruction stream against the model.
        do_reset(1'b1);
        for (int n = 0; n < 150; n++) begin
            op    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 9)];
            funct = 6'($urandom);
            zero  = 1'($urandom);
            opcode = op;
            gen(op, funct, zero, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : 0);
            for (int c = 0; exp_q.size() > 0; c++) begin
                out_t e;
                mem_ready = mr_q.pop_front();
                e = exp_q.pop_front();
                #1 chk($sformatf("model_i%0d_c%0d", n, c), {4'd0, act}, {4'd0, e});
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
